// File: rtl/spi_config_master_if.sv
// Register-write request channel into spi_config_master.
// A request transfers on a clk edge where req_valid && req_ready; the payload is held stable while valid is high.
interface spi_config_master_if;
    logic       req_valid;
    logic       req_ready;
    logic [6:0] req_addr;
    logic [7:0] req_data;

    modport master (output req_valid, req_addr, req_data, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/spi_config_master.sv
// Queues register writes and serialises each one as a 16-bit SPI mode-0 frame {1'b1, addr, data}, MSB first.
// Every output comes straight from a flop. Each flop is loaded from the next-state values computed below.
module spi_config_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP        = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_ADDR   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_config_master_if.slave  req_if,
    output logic                err,
    output logic                done,
    output logic                busy,
    output logic                nCS,
    output logic                SCLK,
    output logic                COPI,
    output logic [2:0]          o_dbg_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t        r_state, w_state_n;
    logic [7:0]    r_hcnt, w_hcnt_n;
    logic [4:0]    r_bcnt, w_bcnt_n;
    logic [15:0]   r_shift, w_shift_n;
    logic          r_sclk, w_sclk_n;
    logic          w_done_n;

    logic [14:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count, w_count_n;
    logic          w_bad, w_push, w_pop;
    logic [14:0]   w_head;

    logic          r_ncs, r_err, r_done, r_busy, r_ready;

    assign w_bad  = req_if.req_addr > 7'(MAX_ADDR);
    assign w_push = req_if.req_valid && r_ready && !w_bad;
    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_state_n = r_state;
        w_hcnt_n  = r_hcnt;
        w_bcnt_n  = r_bcnt;
        w_shift_n = r_shift;
        w_sclk_n  = r_sclk;
        w_done_n  = 1'b0;
        w_pop     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop     = 1'b1;
                    w_shift_n = {1'b1, w_head};
                    w_state_n = S_SETUP;
                    w_hcnt_n  = '0;
                    w_bcnt_n  = '0;
                    w_sclk_n  = 1'b0;
                end
            end
            S_SETUP: begin
                if (r_hcnt == 8'(CLK_DIV - 1)) begin
                    w_state_n = S_SHIFT;
                    w_hcnt_n  = '0;
                    w_bcnt_n  = '0;
                    w_sclk_n  = 1'b1;
                end else begin
                    w_hcnt_n = r_hcnt + 8'd1;
                end
            end
            S_SHIFT: begin
                // COPI only advances on the falling SCLK edge, so it is stable across each rise.
                if (r_hcnt == 8'(CLK_DIV - 1)) begin
                    w_hcnt_n = '0;
                    if (r_sclk) begin
                        w_sclk_n  = 1'b0;
                        w_shift_n = {r_shift[14:0], 1'b0};
                        w_bcnt_n  = r_bcnt + 5'd1;
                    end else if (r_bcnt == 5'd16) begin
                        w_state_n = S_HOLD;
                        w_bcnt_n  = '0;
                    end else begin
                        w_sclk_n = 1'b1;
                    end
                end else begin
                    w_hcnt_n = r_hcnt + 8'd1;
                end
            end
            S_HOLD: begin
                if (r_hcnt == 8'(CLK_DIV - 1)) begin
                    w_state_n = S_GAP;
                    w_hcnt_n  = '0;
                    w_done_n  = 1'b1;
                end else begin
                    w_hcnt_n = r_hcnt + 8'd1;
                end
            end
            S_GAP: begin
                if (r_hcnt == 8'(GAP - 1)) begin
                    w_state_n = S_IDLE;
                    w_hcnt_n  = '0;
                end else begin
                    w_hcnt_n = r_hcnt + 8'd1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_hcnt_n  = '0;
                w_bcnt_n  = '0;
            end
        endcase

        w_count_n = r_count;
        if (w_push && !w_pop) begin
            w_count_n = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_n = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_hcnt   <= '0;
            r_bcnt   <= '0;
            r_shift  <= '0;
            r_sclk   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ncs    <= 1'b1;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state_n;
            r_hcnt   <= w_hcnt_n;
            r_bcnt   <= w_bcnt_n;
            r_shift  <= w_shift_n;
            r_sclk   <= w_sclk_n;
            r_wr_ptr <= w_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop  ? r_rd_ptr + PW'(1) : r_rd_ptr;
            r_count  <= w_count_n;
            r_ncs    <= !((w_state_n == S_SETUP) || (w_state_n == S_SHIFT) || (w_state_n == S_HOLD));
            r_err    <= req_if.req_valid && r_ready && w_bad;
            r_done   <= w_done_n;
            r_busy   <= (w_state_n != S_IDLE) || (w_count_n != '0);
            r_ready  <= w_count_n != CW'(FIFO_DEPTH);
        end
    end

    // Storage needs no reset: only entries below the count are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_if.req_addr, req_if.req_data};
        end
    end

    assign req_if.req_ready = r_ready;
    assign err              = r_err;
    assign done             = r_done;
    assign busy             = r_busy;
    assign nCS              = r_ncs;
    assign SCLK             = r_sclk;
    assign COPI             = r_shift[15];
    assign o_dbg_state      = r_state;

endmodule

// File: doc/spi_config_master.md
# spi_config_master

- Queues register-write requests and serialises them as SPI mode-0 write frames for the chip's SPI register peripheral.
- It is the single source of nCS/SCLK/COPI for that peripheral. It sequences configuration of the output-enable, PWM-enable and duty-cycle registers from on-chip logic, such as a boot sequencer or a test controller.
- Each frame is 16 bits, MSB first: {1'b1 (write), addr[6:0], data[7:0]}.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period. Legal range is 3..255.
- GAP, 8: minimum clk cycles nCS stays high between frames. Legal range is 4..255.
- FIFO_DEPTH, 4: request FIFO entries. Must be a power of two, at least 2.
- MAX_ADDR, 4: highest address the peripheral implements.
- clk  in  1  system clock. Only clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  write request present.
- req_ready  out  1  FIFO can accept. Equals !full. Registered-state-derived, not combinational from req_valid.
- req_addr  in  7  target register address.
- req_data  in  8  write data.
- err  out  1  one-cycle pulse when a request with req_addr > MAX_ADDR is accepted.
- done  out  1  one-cycle pulse when a frame completes (nCS rise).
- busy  out  1  FSM not IDLE, or FIFO non-empty.
- nCS  out  1  chip select, active low.
- SCLK  out  1  serial clock, idles low.
- COPI  out  1  serial data.

## Operation
- Accept rule: a request is accepted on a clk edge where req_valid && req_ready.
  - If req_addr <= MAX_ADDR, the request is pushed to the FIFO.
  - Otherwise it is dropped, err pulses on the following cycle, and the FIFO is unchanged.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop the head, load shifter = {1'b1, addr, data}, go to SETUP.
  - SETUP: nCS=0, SCLK=0, COPI=shifter[15]. Lasts CLK_DIV cycles, then go to SHIFT.
  - SHIFT: 16 bit periods. Each period is SCLK high for CLK_DIV cycles, then low for CLK_DIV cycles.
    - COPI updates to the next bit only on the high→low transition, so it is stable around every rising edge.
    - After the 16th low phase, go to HOLD.
  - HOLD: nCS=0, SCLK=0 for CLK_DIV cycles, then nCS=1, done=1, go to GAP.
  - GAP: nCS=1 for GAP cycles, then go to IDLE.
- Counters:
  - Half-period counter: 8 bits.
  - Bit counter: 5 bits, 0..16.
  - Neither wraps inside a frame. Both reset to 0 on every state entry.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)-bit pointers and a count of log2(FIFO_DEPTH)+1 bits.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop is legal in any non-full state, and the count is unchanged.
  - A push while full cannot occur, because req_ready is low.
  - A pop while empty cannot occur, because IDLE waits.
- Frames are never aborted. Requests arriving mid-frame queue behind the current frame.
- Reset values, asserted asynchronously when rst_n falls, including mid-frame:
  - nCS=1, SCLK=0, COPI=0, err=0, done=0, busy=0, req_ready=1.
  - FIFO empty, FSM in IDLE.
  - A frame cut by reset is incomplete, and the peripheral discards it.

## Timing
- All outputs are registered.
- Accept at edge T into an idle, empty block:
  - pop at edge T+1
  - nCS low from T+1
  - first SCLK rise at T+1+CLK_DIV
- nCS low duration per frame is exactly 32·CLK_DIV + 2·CLK_DIV cycles (136 at CLK_DIV=4).
- Exactly 16 SCLK rising edges occur per frame. SCLK is 0 whenever nCS toggles.
- done is high for exactly one cycle, coincident with the first cycle of nCS high.
- Back-to-back frames:
  - nCS-high time between frames is GAP+1 cycles: GAP plus the IDLE pop cycle.
  - This is at least 5 clk, which satisfies the peripheral's 2-flop synchroniser plus edge detect.
- CLK_DIV ≥ 3 guarantees that every SCLK level and every COPI value is seen by the peripheral's synchronisers.

## Test plan
- Single write, addr 2, data 0xA5, CLK_DIV=4:
  - COPI sampled at SCLK rises = 0x82A5 MSB first.
  - 16 rises; nCS low 136 cycles; one done pulse.
  - Peripheral en_reg_pwm_7_0 = 0xA5.
- req_valid held with addrs 0..4 for 6 consecutive cycles from idle:
  - Exactly 5 accepted; req_ready low in cycle 6.
  - Five frames in order, each separated by ≥ GAP+1 nCS-high cycles.
  - All five peripheral registers updated.
- req_addr=5, data 0xFF:
  - err pulses 1 cycle; no nCS activity; busy stays 0.
  - Peripheral registers unchanged.
- Push during SHIFT of frame 1:
  - Frame 1 bit stream is unaffected.
  - Frame 2 starts only after GAP.
  - 8 FIFO push/pop cycles exercise pointer wrap; data order is preserved.
- Reset mid-frame: assert rst_n=0 after 7 SCLK rises.
  - Immediately nCS=1, SCLK=0, FIFO empty.
  - Peripheral registers are unchanged.
  - After release, a new write (addr 4, 0x80) completes correctly.
- CLK_DIV=3, GAP=4 sweep with random addr/data ≤ MAX_ADDR:
  - Peripheral register contents match a scoreboard after every done.
